// File: rtl/sd_spi_pkg.sv
// Shared encodings for the SPI-mode SD card engine: command IDs, FSM states
// and the INIT dummy-clock count.
package sd_spi_pkg;

    localparam logic [1:0] SD_CMD_INIT  = 2'd0;
    localparam logic [1:0] SD_CMD_XCHG  = 2'd1;
    localparam logic [1:0] SD_CMD_CS_LO = 2'd2;
    localparam logic [1:0] SD_CMD_CS_HI = 2'd3;

    localparam int INIT_PULSES = 80;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        XCHG,
        CSSET
    } state_t;

endpackage

// File: rtl/sd_spi_shifter.sv
// SCLK divider, 8-bit MSB-first shift register and bit/pulse counter (SPI mode 0).
// INIT mode holds MOSI high and emits INIT_PULSES clocks; XCHG mode moves one byte.
import sd_spi_pkg::*;

module sd_spi_shifter #(
    parameter int HW = 6
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          init_mode,
    input  logic [HW-1:0] half,
    input  logic [7:0]    tx_byte,
    input  logic          miso,
    output logic          sclk,
    output logic          mosi,
    output logic          done,
    output logic [7:0]    rx_byte
);

    logic          active;
    logic          mode_init;
    logic [HW-1:0] half_q;
    logic [HW-1:0] half_m1;
    logic [HW-1:0] div_cnt;
    logic [6:0]    pulse_cnt;
    logic [6:0]    last_pulse;
    logic [7:0]    shreg;
    logic          tick;
    logic          sample;

    assign half_m1    = half_q - HW'(1);
    assign tick       = active && (div_cnt == half_m1);
    assign last_pulse = mode_init ? 7'(INIT_PULSES - 1) : 7'd7;
    assign done       = tick && sclk && (pulse_cnt == last_pulse);
    // Sample in the first high cycle so the synchronized MISO has settled.
    assign sample     = active && sclk && (div_cnt == '0) && !mode_init;
    assign rx_byte    = shreg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            active    <= 1'b0;
            mode_init <= 1'b0;
            half_q    <= '0;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            shreg     <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b1;
        end else if (start) begin
            active    <= 1'b1;
            mode_init <= init_mode;
            half_q    <= half;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            shreg     <= tx_byte;
            sclk      <= 1'b0;
            mosi      <= init_mode ? 1'b1 : tx_byte[7];
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk      <= 1'b0;
                    pulse_cnt <= pulse_cnt + 7'd1;
                    if (done) begin
                        active <= 1'b0;
                        mosi   <= 1'b1;
                    end else if (!mode_init) begin
                        mosi <= shreg[7];
                    end
                end
            end else begin
                div_cnt <= div_cnt + HW'(1);
            end
            if (sample)
                shreg <= {shreg[6:0], miso};
        end
    end

endmodule

// File: rtl/sd_spi_ctl.sv
// SPI-mode SD card engine behind the FEh/FFh port registers: strobe detect,
// command FSM, chip select, timeout. Optional fast-clock select: SD_SPEED_SEL_EN.
import sd_spi_pkg::*;

module sd_spi_ctl #(
    parameter int DIV_SLOW       = 32,
    parameter int DIV_FAST       = 2,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       sd_signal,
    input  logic [1:0] sd_cmd,
    input  logic [7:0] sd_out,
    output logic [7:0] sd_din,
    output logic       sd_busy,
    output logic       sd_timeout,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    // DIV_FAST never exceeds DIV_SLOW in a sane build, so this is the slow width.
    localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int HW      = $clog2(DIV_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_n;
    logic          sig_q, sig_prev;
    logic          miso_q1, miso_q2;
    logic          accept;
    logic          start;
    logic          done;
    logic [HW-1:0] half;
    logic [7:0]    rx_byte;
    logic [TW-1:0] tmo_cnt;

    assign accept     = sig_q && !sig_prev && (state == IDLE);
    assign start      = accept && (sd_cmd == SD_CMD_INIT || sd_cmd == SD_CMD_XCHG);
    assign sd_busy    = (state != IDLE);
    assign sd_timeout = (tmo_cnt == TW'(TIMEOUT_CYCLES));

`ifdef SD_SPEED_SEL_EN
    logic speed;

    assign half = (sd_cmd == SD_CMD_INIT || !speed) ? HW'(DIV_SLOW) : HW'(DIV_FAST);

    always_ff @(posedge clock) begin
        if (!resetn)
            speed <= 1'b0;
        else if (accept && sd_cmd == SD_CMD_INIT)
            speed <= 1'b0;
        else if (accept && sd_cmd == SD_CMD_CS_HI)
            speed <= sd_out[0];
    end
`else
    assign half = HW'(DIV_SLOW);
`endif

    always_ff @(posedge clock) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (sd_cmd)
                        SD_CMD_INIT: state_n = INIT;
                        SD_CMD_XCHG: state_n = XCHG;
                        default:     state_n = CSSET;
                    endcase
                end
            end
            INIT, XCHG: if (done) state_n = IDLE;
            CSSET:      state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sig_q    <= 1'b0;
            sig_prev <= 1'b0;
            miso_q1  <= 1'b1;
            miso_q2  <= 1'b1;
            sd_din   <= 8'hFF;
            spi_cs_n <= 1'b1;
            tmo_cnt  <= '0;
        end else begin
            sig_q    <= sd_signal;
            sig_prev <= sig_q;
            miso_q1  <= spi_miso;
            miso_q2  <= miso_q1;
            if (accept) begin
                case (sd_cmd)
                    SD_CMD_INIT, SD_CMD_CS_HI: spi_cs_n <= 1'b1;
                    SD_CMD_CS_LO:              spi_cs_n <= 1'b0;
                    default:                   ;
                endcase
            end
            if (done && state == XCHG)
                sd_din <= rx_byte;
            if (accept)
                tmo_cnt <= '0;
            else if (!sd_timeout)
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    sd_spi_shifter #(.HW(HW)) u_shifter (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .init_mode (sd_cmd == SD_CMD_INIT),
        .half      (half),
        .tx_byte   (sd_out),
        .miso      (miso_q2),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .done      (done),
        .rx_byte   (rx_byte)
    );

endmodule

// File: tb/tb_sd_spi_ctl.sv
// Bench for sd_spi_ctl: card model shifts MISO on SCLK falls and captures MOSI
// on rises; expected exchanges are queued at stimulus and checked at busy fall.
import sd_spi_pkg::*;

module tb_sd_spi_ctl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       sd_signal;
    logic [1:0] sd_cmd;
    logic [7:0] sd_out;
    logic [7:0] sd_din;
    logic       sd_busy;
    logic       sd_timeout;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [7:0] exp_din[$];
    logic [7:0] exp_mosi[$];
    int         exp_len[$];

    sd_spi_ctl #(.DIV_SLOW(32), .DIV_FAST(2), .TIMEOUT_CYCLES(100)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .sd_signal  (sd_signal),
        .sd_cmd     (sd_cmd),
        .sd_out     (sd_out),
        .sd_din     (sd_din),
        .sd_busy    (sd_busy),
        .sd_timeout (sd_timeout),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Card model: presents MSB first, advances on each SCLK fall.
    logic [7:0] miso_sh  = 8'hFF;
    logic [7:0] load_val = 8'hFF;
    logic       load_tgl = 1'b0;
    logic       load_seen = 1'b0;
    logic       sclk_d   = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    int         rise_cnt = 0;

    always @(negedge clock) begin
        if (load_tgl != load_seen) begin
            load_seen = load_tgl;
            miso_sh   = load_val;
        end else if (sclk_d && !spi_sclk) begin
            miso_sh = {miso_sh[6:0], 1'b1};
        end
        if (!sclk_d && spi_sclk) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            rise_cnt++;
        end
        sclk_d   = spi_sclk;
        spi_miso = miso_sh[7];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [1:0] cmd, input logic [7:0] data);
        sd_cmd    = cmd;
        sd_out    = data;
        sd_signal = 1'b1;
        tick;
        tick;
        sd_signal = 1'b0;
    endtask

    task automatic card_load(input logic [7:0] b);
        load_val = b;
        load_tgl = ~load_tgl;
        tick;
    endtask

    task automatic wait_idle(input int t0, output int len);
        while (sd_busy && (cyc - t0) < 20000) tick;
        len = cyc - t0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; sd_signal = 1'b0; sd_cmd = 2'd0; sd_out = 8'h00;
        repeat (3) tick;
        total_cnt++; if (sd_din !== 8'hFF) $display("FAIL rst_din: got %h want ff", sd_din); else pass_cnt++;
        total_cnt++; if (sd_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", sd_busy); else pass_cnt++;
        total_cnt++; if (sd_timeout !== 1'b0) $display("FAIL rst_tmo: got %b want 0", sd_timeout); else pass_cnt++;
        total_cnt++; if (spi_sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", spi_sclk); else pass_cnt++;
        total_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); else pass_cnt++;
        total_cnt++; if (spi_mosi !== 1'b1) $display("FAIL rst_mosi: got %b want 1", spi_mosi); else pass_cnt++;
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_init;
        int r0, t0, len, bad;
        bad = 0;
        r0 = rise_cnt;
        strobe(SD_CMD_INIT, 8'h00);
        t0 = cyc;
        while (sd_busy && (cyc - t0) < 20000) begin
            if (spi_cs_n !== 1'b1 || spi_mosi !== 1'b1) bad++;
            tick;
        end
        len = cyc - t0;
        total_cnt++; if (len != 5120) $display("FAIL init_len: got %0d want 5120", len); else pass_cnt++;
        total_cnt++; if (rise_cnt - r0 != 80) $display("FAIL init_pulses: got %0d want 80", rise_cnt - r0); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL init_lines: got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (sd_din !== 8'hFF) $display("FAIL init_din: got %h want ff", sd_din); else pass_cnt++;
    endtask

    task automatic test_xchg;
        int r0, len, e_len;
        logic [7:0] e_din, e_mosi;
        strobe(SD_CMD_CS_LO, 8'h00);
        wait_idle(cyc, len);
        total_cnt++; if (len != 1) $display("FAIL cslo_len: got %0d want 1", len); else pass_cnt++;
        total_cnt++; if (spi_cs_n !== 1'b0) $display("FAIL cslo_cs_n: got %b want 0", spi_cs_n); else pass_cnt++;
        card_load(8'hA5);
        exp_din.push_back(8'hA5); exp_mosi.push_back(8'h40); exp_len.push_back(512);
        r0 = rise_cnt;
        strobe(SD_CMD_XCHG, 8'h40);
        wait_idle(cyc, len);
        e_din = exp_din.pop_front(); e_mosi = exp_mosi.pop_front(); e_len = exp_len.pop_front();
        total_cnt++; if (sd_din !== e_din) $display("FAIL xchg_din: got %h want %h", sd_din, e_din); else pass_cnt++;
        total_cnt++; if (mosi_cap !== e_mosi) $display("FAIL xchg_mosi: got %h want %h", mosi_cap, e_mosi); else pass_cnt++;
        total_cnt++; if (len != e_len) $display("FAIL xchg_len: got %0d want %0d", len, e_len); else pass_cnt++;
        total_cnt++; if (rise_cnt - r0 != 8) $display("FAIL xchg_rises: got %0d want 8", rise_cnt - r0); else pass_cnt++;
        total_cnt++; if (spi_mosi !== 1'b1) $display("FAIL xchg_mosi_idle: got %b want 1", spi_mosi); else pass_cnt++;
    endtask

    task automatic test_drop;
        int r0, t0, len, e_len;
        logic [7:0] e_din, e_mosi;
        card_load(8'h3C);
        exp_din.push_back(8'h3C); exp_mosi.push_back(8'h96); exp_len.push_back(512);
        r0 = rise_cnt;
        strobe(SD_CMD_XCHG, 8'h96);
        t0 = cyc;
        repeat (100) tick;
        strobe(SD_CMD_XCHG, 8'h00);
        wait_idle(t0, len);
        e_din = exp_din.pop_front(); e_mosi = exp_mosi.pop_front(); e_len = exp_len.pop_front();
        total_cnt++; if (sd_din !== e_din) $display("FAIL drop_din: got %h want %h", sd_din, e_din); else pass_cnt++;
        total_cnt++; if (mosi_cap !== e_mosi) $display("FAIL drop_mosi: got %h want %h", mosi_cap, e_mosi); else pass_cnt++;
        total_cnt++; if (len != e_len) $display("FAIL drop_len: got %0d want %0d", len, e_len); else pass_cnt++;
        total_cnt++; if (rise_cnt - r0 != 8) $display("FAIL drop_rises: got %0d want 8", rise_cnt - r0); else pass_cnt++;
        card_load(8'h5A);
        exp_din.push_back(8'h5A); exp_mosi.push_back(8'hC3); exp_len.push_back(512);
        strobe(SD_CMD_XCHG, 8'hC3);
        wait_idle(cyc, len);
        e_din = exp_din.pop_front(); e_mosi = exp_mosi.pop_front(); e_len = exp_len.pop_front();
        total_cnt++; if (sd_din !== e_din) $display("FAIL next_din: got %h want %h", sd_din, e_din); else pass_cnt++;
        total_cnt++; if (mosi_cap !== e_mosi) $display("FAIL next_mosi: got %h want %h", mosi_cap, e_mosi); else pass_cnt++;
        total_cnt++; if (len != e_len) $display("FAIL next_len: got %0d want %0d", len, e_len); else pass_cnt++;
    endtask

    task automatic test_speed;
        int len, e_len;
        logic [7:0] e_din, e_mosi;
        strobe(SD_CMD_CS_HI, 8'h01);
        wait_idle(cyc, len);
        total_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL cshi_cs_n: got %b want 1", spi_cs_n); else pass_cnt++;
        card_load(8'hE7);
`ifdef SD_SPEED_SEL_EN
        exp_din.push_back(8'hE7); exp_mosi.push_back(8'h18); exp_len.push_back(32);
`else
        exp_din.push_back(8'hE7); exp_mosi.push_back(8'h18); exp_len.push_back(512);
`endif
        strobe(SD_CMD_XCHG, 8'h18);
        wait_idle(cyc, len);
        e_din = exp_din.pop_front(); e_mosi = exp_mosi.pop_front(); e_len = exp_len.pop_front();
        total_cnt++; if (sd_din !== e_din) $display("FAIL spd_din: got %h want %h", sd_din, e_din); else pass_cnt++;
        total_cnt++; if (mosi_cap !== e_mosi) $display("FAIL spd_mosi: got %h want %h", mosi_cap, e_mosi); else pass_cnt++;
        total_cnt++; if (len != e_len) $display("FAIL spd_len: got %0d want %0d", len, e_len); else pass_cnt++;
        strobe(SD_CMD_INIT, 8'h01);
        wait_idle(cyc, len);
        card_load(8'h81);
        exp_din.push_back(8'h81); exp_mosi.push_back(8'h7E); exp_len.push_back(512);
        strobe(SD_CMD_XCHG, 8'h7E);
        wait_idle(cyc, len);
        e_din = exp_din.pop_front(); e_mosi = exp_mosi.pop_front(); e_len = exp_len.pop_front();
        total_cnt++; if (sd_din !== e_din) $display("FAIL slow_din: got %h want %h", sd_din, e_din); else pass_cnt++;
        total_cnt++; if (mosi_cap !== e_mosi) $display("FAIL slow_mosi: got %h want %h", mosi_cap, e_mosi); else pass_cnt++;
        total_cnt++; if (len != e_len) $display("FAIL slow_len: got %0d want %0d", len, e_len); else pass_cnt++;
    endtask

    task automatic test_timeout;
        strobe(SD_CMD_CS_LO, 8'h00);
        total_cnt++; if (sd_timeout !== 1'b0) $display("FAIL tmo_clear0: got %b want 0", sd_timeout); else pass_cnt++;
        repeat (99) tick;
        total_cnt++; if (sd_timeout !== 1'b0) $display("FAIL tmo_99: got %b want 0", sd_timeout); else pass_cnt++;
        tick;
        total_cnt++; if (sd_timeout !== 1'b1) $display("FAIL tmo_100: got %b want 1", sd_timeout); else pass_cnt++;
        repeat (20) tick;
        total_cnt++; if (sd_timeout !== 1'b1) $display("FAIL tmo_hold: got %b want 1", sd_timeout); else pass_cnt++;
        strobe(SD_CMD_CS_LO, 8'h00);
        total_cnt++; if (sd_timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", sd_timeout); else pass_cnt++;
        tick;
    endtask

    task automatic test_reset_mid;
        int r0, guard;
        card_load(8'hC3);
        r0 = rise_cnt;
        strobe(SD_CMD_XCHG, 8'h5A);
        guard = 0;
        while ((rise_cnt - r0) < 4 && guard < 2000) begin
            tick;
            guard++;
        end
        total_cnt++; if (rise_cnt - r0 < 4) $display("FAIL mid_reach_bit3: got %0d rises want 4", rise_cnt - r0); else pass_cnt++;
        resetn = 1'b0;
        tick;
        total_cnt++; if (spi_sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", spi_sclk); else pass_cnt++;
        total_cnt++; if (spi_cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", spi_cs_n); else pass_cnt++;
        total_cnt++; if (sd_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", sd_busy); else pass_cnt++;
        total_cnt++; if (sd_din !== 8'hFF) $display("FAIL mid_din: got %h want ff", sd_din); else pass_cnt++;
        resetn = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_init;
        test_xchg;
        test_drop;
        test_speed;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
